// File: rtl/wb_egress_packer.sv
// rtl/wb_egress_packer.sv - packs accepted WB beats into tagged command/data words and queues them for the egress FIFO
// Optional overflow checking: define WB_EGRESS_PACKER_OVF_CHK_EN.
module wb_egress_packer #(
    parameter  int ADR_W  = 24,
    parameter  int DAT_W  = 32,
    parameter  int DEPTH  = 4,
    localparam int FIFO_W = DAT_W + DAT_W / 8 + 2
) (
    input  logic               wb_clk,
    input  logic               wb_rst,
    input  logic [ADR_W-1:0]   wb_adr_i,
    input  logic [DAT_W-1:0]   wb_dat_i,
    input  logic [DAT_W/8-1:0] wb_sel_i,
    input  logic               wb_we_i,
    input  logic [2:0]         wb_cti_i,
    input  logic [1:0]         wb_bte_i,
    input  logic               state_idle_i,
    input  logic               egress_fifo_we_i,
    output logic               egress_fifo_full_o,
    output logic [FIFO_W-1:0]  fifo_dat_o,
    output logic               fifo_we_o,
    input  logic               fifo_full_i,
    output logic               ovf_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);
    localparam logic [AW:0] TWO_P   = (AW+1)'(2);

    logic [FIFO_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr, count, count_next;
    logic [AW:0]       n_acc_w, pop_w;
    logic [AW-1:0]     wr_idx1;
    logic [1:0]        n_req, n_acc;
    logic              last, pop, full_q;
    logic [FIFO_W-1:0] cmd_word, data_word, word0;

    always_comb begin
        count     = wr_ptr - rd_ptr;
        last      = (wb_cti_i == 3'b000) || (wb_cti_i == 3'b111);
        cmd_word  = '0;
        cmd_word[FIFO_W-1]  = 1'b1;
        cmd_word[ADR_W+5:0] = {wb_we_i, wb_bte_i, wb_cti_i, wb_adr_i};
        data_word = {1'b0, last, wb_sel_i, wb_dat_i};
        word0     = state_idle_i ? cmd_word : data_word;
        pop       = (count != '0) && !fifo_full_i;
        if (!egress_fifo_we_i)
            n_req = 2'd0;
        else if (state_idle_i && wb_we_i)
            n_req = 2'd2;
        else
            n_req = 2'd1;
    end

`ifdef WB_EGRESS_PACKER_OVF_CHK_EN
    logic [AW:0] free, n_req_w;
    logic        ovf_set, ovf_q;

    // Only the words that fit are accepted; the rest are dropped and flagged.
    always_comb begin
        free    = DEPTH_P - count;
        n_req_w = (AW+1)'(n_req);
        ovf_set = n_req_w > free;
        n_acc   = ovf_set ? free[1:0] : n_req;
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst)
            ovf_q <= 1'b0;
        else if (ovf_set)
            ovf_q <= 1'b1;
    end

    assign ovf_o = ovf_q;
`else
    assign n_acc = n_req;
    assign ovf_o = 1'b0;
`endif

    always_comb begin
        n_acc_w    = (AW+1)'(n_acc);
        pop_w      = (AW+1)'(pop);
        count_next = count + n_acc_w - pop_w;
        wr_idx1    = wr_ptr[AW-1:0] + 1'b1;
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (n_acc != 2'd0)
                mem[wr_ptr[AW-1:0]] <= word0;
            if (n_acc == 2'd2)
                mem[wr_idx1] <= data_word;
            wr_ptr <= wr_ptr + n_acc_w;
            rd_ptr <= rd_ptr + pop_w;
            // Registered so the control FSM never sees a path from fifo_full_i.
            full_q <= (DEPTH_P - count_next) < TWO_P;
        end
    end

    assign fifo_we_o          = pop;
    assign fifo_dat_o         = mem[rd_ptr[AW-1:0]];
    assign egress_fifo_full_o = full_q;
endmodule
